// File: rtl/nuc970_ecc_ctrl_if.sv
// rtl/nuc970_ecc_ctrl_if.sv - host, decoder and output stream signals of nuc970_ecc_ctrl
interface nuc970_ecc_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dec_data_out;
  logic       dec_start_out;
  logic       dec_first_in;
  logic [7:0] dec_err_in;
  logic [7:0] dec_err_cnt_in;
  logic       dec_err_last_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_data, in_valid, dec_first_in, dec_err_in, dec_err_cnt_in, dec_err_last_in, out_ready,
    input  in_ready, dec_data_out, dec_start_out, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, dec_first_in, dec_err_in, dec_err_cnt_in, dec_err_last_in, out_ready,
    output in_ready, dec_data_out, dec_start_out, out_data, out_valid, out_last
  );
endinterface

// File: rtl/nuc970_ecc_ctrl.sv
// rtl/nuc970_ecc_ctrl.sv - sector buffer sequencing an external BCH decoder and streaming corrected data
// Statistics counters are built only when NUC970_ECC_STATS_EN is defined.
module nuc970_ecc_ctrl #(
  parameter int SECTOR_BYTES = 544,
  parameter int T            = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  nuc970_ecc_ctrl_if.slave  bus,
  output logic              busy_out,
  output logic              done_out,
  output logic              fail_out,
  output logic [7:0]        err_cnt_out,
  output logic [15:0]       stat_sectors_out,
  output logic [15:0]       stat_bits_out
);
  localparam int IW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(SECTOR_BYTES - 1);
  localparam logic [TW-1:0] LAST_TMR = TW'(TIMEOUT - 1);
  localparam logic [7:0]    T8       = 8'(T);

  typedef enum logic [2:0] {IDLE, FILL, FEED, WAIT, CORRECT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          in_ready_q, in_ready_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [7:0]    err_q, err_d;
  logic          seen_q, seen_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [SECTOR_BYTES];
  logic          wr_en;
  logic [IW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic          accept;

  assign accept = in_ready_q & bus.in_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    fail_d  = fail_q;
    err_d   = err_q;
    seen_d  = seen_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = bus.in_data;
    rd_addr = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          fail_d  = 1'b0;
          err_d   = 8'h00;
          seen_d  = 1'b0;
          idx_d   = IW'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        rd_addr = '0;
        if (accept) begin
          wr_en = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FEED;
          end
        end
      end
      FEED: begin
        rd_addr = idx_q + IW'(1);
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          rd_addr = '0;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        rd_addr = '0;
        // the first_out cycle already carries the mask for byte 0
        if (bus.dec_first_in) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          wr_data = rd_data_q ^ bus.dec_err_in;
          rd_addr = IW'(1);
          idx_d   = IW'(1);
          state_d = CORRECT;
          if (bus.dec_err_last_in) begin
            err_d  = bus.dec_err_cnt_in;
            fail_d = bus.dec_err_cnt_in > T8;
            seen_d = 1'b1;
          end
        end else if (tmr_q == LAST_TMR) begin
          fail_d  = 1'b1;
          err_d   = 8'hFF;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      CORRECT: begin
        wr_en   = 1'b1;
        wr_data = rd_data_q ^ bus.dec_err_in;
        rd_addr = idx_q + IW'(1);
        idx_d   = idx_q + IW'(1);
        if (bus.dec_err_last_in) begin
          err_d  = bus.dec_err_cnt_in;
          fail_d = bus.dec_err_cnt_in > T8;
          seen_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          rd_addr = '0;
          idx_d   = '0;
          if (!(seen_q || bus.dec_err_last_in)) begin
            fail_d = 1'b1;
            err_d  = 8'hFF;
          end
          if (fail_d) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            rd_addr = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == FILL);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_q      <= 8'h00;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
    end
  end

  // buffer survives reset; only the sequencing state is cleared
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.dec_data_out  = rd_data_q;
  assign bus.dec_start_out = (state_q == FEED) && (idx_q == '0);
  assign bus.out_data      = rd_data_q;
  assign bus.out_valid     = (state_q == DRAIN);
  assign bus.out_last      = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign busy_out          = (state_q != IDLE);
  assign done_out          = done_q;
  assign fail_out          = fail_q;
  assign err_cnt_out       = err_q;

`ifdef NUC970_ECC_STATS_EN
  logic [15:0] sec_q, sec_d, bits_q, bits_d;
  logic [16:0] bits_sum;

  always_comb begin
    sec_d    = sec_q;
    bits_d   = bits_q;
    bits_sum = {1'b0, bits_q} + {9'd0, err_d};
    if (done_q && (sec_q != 16'hFFFF)) sec_d = sec_q + 16'd1;
    if ((state_q == CORRECT) && (state_d == DRAIN))
      bits_d = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sec_q  <= 16'd0;
      bits_q <= 16'd0;
    end else begin
      sec_q  <= sec_d;
      bits_q <= bits_d;
    end
  end

  assign stat_sectors_out = sec_q;
  assign stat_bits_out    = bits_q;
`else
  assign stat_sectors_out = 16'd0;
  assign stat_bits_out    = 16'd0;
`endif
endmodule

// File: tb/tb_nuc970_ecc_ctrl.sv
// tb/tb_nuc970_ecc_ctrl.sv - randomized self-checking bench for nuc970_ecc_ctrl
module tb_nuc970_ecc_ctrl;
  localparam int N     = 544;
  localparam int TT    = 4;
  localparam int TO    = 4096;
  localparam int BOUND = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done, fail;
  logic [7:0]  err_cnt;
  logic [15:0] stat_sec, stat_bits;

  always #5 clk = ~clk;

  nuc970_ecc_ctrl_if bus ();

  nuc970_ecc_ctrl #(.SECTOR_BYTES(N), .T(TT), .TIMEOUT(TO)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .bus              (bus),
    .busy_out         (busy),
    .done_out         (done),
    .fail_out         (fail),
    .err_cnt_out      (err_cnt),
    .stat_sectors_out (stat_sec),
    .stat_bits_out    (stat_bits)
  );

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int out_seen = 0;
  int sec_m = 0;
  int bits_m = 0;
  logic [7:0] clean [N];
  logic [7:0] mask  [N];
  logic [7:0] tx    [N];
  logic [7:0] rx    [$];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic prep(input bit all_ff, input int nbits);
    int placed;
    int p;
    for (int i = 0; i < N; i++) begin
      clean[i] = all_ff ? 8'hFF : 8'($urandom);
      mask[i]  = 8'h00;
    end
    placed = 0;
    while (placed < nbits) begin
      p = $urandom_range(0, N - 1);
      if (mask[p] == 8'h00) begin
        mask[p] = 8'(1 << $urandom_range(0, 7));
        placed++;
      end
    end
  endtask

  task automatic send_sector(input int gap);
    int i;
    int cyc;
    bit hs;
    i = 0;
    cyc = 0;
    while (i < N && cyc < BOUND) begin
      bus.in_valid        = ($urandom_range(0, 99) >= gap);
      bus.in_data         = tx[i];
      bus.dec_first_in    = ($urandom_range(0, 7) == 0);
      bus.dec_err_last_in = ($urandom_range(0, 7) == 0);
      bus.dec_err_cnt_in  = 8'($urandom);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    bus.in_valid        = 1'b0;
    bus.dec_first_in    = 1'b0;
    bus.dec_err_last_in = 1'b0;
    bus.dec_err_cnt_in  = 8'h00;
    if (i < N) chk_val("send_timeout", i, N);
  endtask

  task automatic dec_model(input bit give_first, input int dly, input int lp, input logic [7:0] rep);
    int cyc;
    cyc = 0;
    while (bus.dec_start_out !== 1'b1 && cyc < BOUND) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.dec_start_out !== 1'b1) begin
      chk_val("dec_start_seen", 0, 1);
      return;
    end
    for (int k = 0; k < N; k++) begin
      chk_val("feed_data", bus.dec_data_out, tx[k]);
      chk_val("feed_start", bus.dec_start_out, (k == 0));
      @(posedge clk); #1;
    end
    if (!give_first) return;
    repeat (dly) begin @(posedge clk); #1; end
    for (int k = 0; k < N; k++) begin
      bus.dec_first_in    = (k == 0);
      bus.dec_err_in      = mask[k];
      bus.dec_err_last_in = (k == lp);
      bus.dec_err_cnt_in  = (k == lp) ? rep : 8'($urandom);
      @(posedge clk); #1;
    end
    bus.dec_first_in    = 1'b0;
    bus.dec_err_in      = 8'h00;
    bus.dec_err_last_in = 1'b0;
    bus.dec_err_cnt_in  = 8'h00;
  endtask

  task automatic sink(input int rdy_pct, input int d0);
    int cyc;
    bit stall;
    logic [7:0] prev;
    cyc = 0;
    stall = 1'b0;
    prev = 8'h00;
    rx.delete();
    while (done_cnt == d0 && cyc < BOUND) begin
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (bus.out_valid === 1'b1) begin
        out_seen++;
        if (stall) chk_val("hold", bus.out_data, prev);
        if (bus.out_ready) begin
          rx.push_back(bus.out_data);
          chk_val("out_last", bus.out_last, (rx.size() == N));
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          prev = bus.out_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (done_cnt == d0) chk_val("done_timeout", 0, 1);
  endtask

  task automatic check_stats;
`ifdef NUC970_ECC_STATS_EN
    chk_val("stat_sectors", stat_sec, sec_m);
    chk_val("stat_bits", stat_bits, bits_m);
`else
    chk_val("stat_sectors", stat_sec, 0);
    chk_val("stat_bits", stat_bits, 0);
`endif
  endtask

  task automatic run_sector(input bit give_first, input int lp, input logic [7:0] rep,
                            input int gap, input int rdy);
    int d0;
    int dly;
    bit exp_fail;
    logic [7:0] exp_err;
    for (int i = 0; i < N; i++) tx[i] = clean[i] ^ mask[i];
    d0 = done_cnt;
    out_seen = 0;
    dly = $urandom_range(0, 20);
    fork
      send_sector(gap);
      dec_model(give_first, dly, lp, rep);
      sink(rdy, d0);
    join
    exp_fail = !give_first || (lp < 0) || (rep > TT);
    exp_err  = (!give_first || (lp < 0)) ? 8'hFF : rep;
    chk_val("fail_out", fail, exp_fail);
    chk_val("err_cnt_out", err_cnt, exp_err);
    repeat (3) begin @(posedge clk); #1; end
    chk_val("done_pulses", done_cnt - d0, 1);
    if (exp_fail) begin
      chk_val("no_output", out_seen, 0);
    end else begin
      chk_val("out_count", rx.size(), N);
      for (int i = 0; i < N && i < rx.size(); i++) chk_val("out_data", rx[i], clean[i]);
    end
    chk_val("busy_idle", busy, 0);
    chk_val("in_ready_idle", bus.in_ready, 1);
    sec_m++;
    if (!exp_fail) bits_m += rep;
    check_stats();
  endtask

  task automatic reset_check(input bit wait_edge);
    rst_n = 1'b0;
    if (wait_edge) begin @(posedge clk); #1; end
    else #1;
    chk_val("rst_in_ready", bus.in_ready, 0);
    chk_val("rst_dec_start", bus.dec_start_out, 0);
    chk_val("rst_out_valid", bus.out_valid, 0);
    chk_val("rst_out_last", bus.out_last, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_fail", fail, 0);
    chk_val("rst_err_cnt", err_cnt, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_stat_sec", stat_sec, 0);
    chk_val("rst_stat_bits", stat_bits, 0);
    sec_m = 0;
    bits_m = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk_val("rst_in_ready_held", bus.in_ready, 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk_val("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    bus.dec_first_in = 1'b0;
    bus.dec_err_in = 8'h00;
    bus.dec_err_cnt_in = 8'h00;
    bus.dec_err_last_in = 1'b0;
    reset_check(1'b1);

    prep(1'b1, 0);
    run_sector(1'b1, N - 1, 8'd0, 0, 100);
    prep(1'b0, 0);
    mask[168] = 8'h10;
    mask[293] = 8'h10;
    mask[504] = 8'h24;
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd4, 0, 100);
    prep(1'b0, 5);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd5, 10, 100);
    prep(1'b0, 1);
    run_sector(1'b0, 0, 8'd1, 0, 100);
    prep(1'b0, 3);
    run_sector(1'b1, -1, 8'd3, 0, 100);
    prep(1'b0, 2);
    run_sector(1'b1, 0, 8'd2, 30, 50);
    prep(1'b0, 4);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd4, 40, 35);

    prep(1'b0, 0);
    for (int i = 0; i < N; i++) tx[i] = clean[i];
    send_sector(0);
    repeat (3) begin @(posedge clk); #1; end
    chk_val("mid_feed_busy", busy, 1);
    reset_check(1'b0);
    prep(1'b0, 3);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd3, 25, 60);

    reset_check(1'b0);
    prep(1'b0, 2);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd2, 20, 70);
    prep(1'b0, 0);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd0, 20, 70);
    prep(1'b0, 4);
    run_sector(1'b1, $urandom_range(0, N - 1), 8'd4, 20, 70);
`ifdef NUC970_ECC_STATS_EN
    chk_val("stat_sectors_3", stat_sec, 3);
    chk_val("stat_bits_6", stat_bits, 6);
`else
    chk_val("stat_sectors_off", stat_sec, 0);
    chk_val("stat_bits_off", stat_bits, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
